rtc_bus_arbiter: RTL and testbench
==================================

// Module: rtc_bus_arbiter
// PURPOSE
//  Shares the single RTC transaction engine (read-all, write-time, write-date, write-chrono, init)
//  between the control FSM, the programming logic and an internal periodic-refresh timer.
//  Captures request pulses, grants one at a time by fixed priority, drives the engine's
//  go/select lines and returns a per-requester acknowledge when the engine reports done.
// PARAMETERS
//  REFRESH_CYCLES  12500000  clock cycles between automatic read-all requests (>=4)
//  TIMEOUT_CYCLES  4096      max WAIT cycles before abort (used only with RTC_ARB_TIMEOUT_EN)
// PORTS
//  clock        in   1  system clock, all logic on rising edge
//  reset        in   1  synchronous, active-high reset
//  req          in   5  request pulses: [0]=init [1]=wr time [2]=wr date [3]=wr chrono [4]=read-all
//  eng_done     in   1  one-cycle pulse from transaction engine: current transaction finished
//  go           out  1  one-cycle start pulse to engine
//  sel          out  3  engine command: 0 none,1 init,2 read-all,3 wr time,4 wr date,5 wr chrono
//  gnt          out  5  one-hot, bit of requester being served (same mapping as req)
//  ack          out  5  one-cycle pulse on served bit when transaction completes
//  busy         out  1  high from ISSUE through RELEASE
//  timeout_err  out  1  sticky abort flag (0 when macro disabled)
// BEHAVIOUR
//  - Reset: go=0, sel=0, gnt=0, ack=0, busy=0, timeout_err=0, state=IDLE, refresh cnt=0,
//    pend=5'b00001 (init auto-requested after every reset).
//  - pend[i] set on cycle after req[i]=1; cleared in RELEASE for the granted bit only.
//    Set wins over clear (req[i] in RELEASE cycle leaves pend[i]=1). Repeat pulses merge.
//  - Refresh cnt 0..REFRESH_CYCLES-1 free-running; at wrap sets pend[4]. Never paused.
//  - Priority: bit0 > bit1 > bit2 > bit3 > bit4 (fixed; no rotation).
//  - FSM: IDLE -> ISSUE when pend!=0 (winner latched into gnt/sel);
//    ISSUE: go=1 for exactly this cycle -> WAIT;
//    WAIT: eng_done=1 -> RELEASE (eng_done during ISSUE ignored);
//    RELEASE: ack[gnt]=1 one cycle, clear pend bit -> IDLE; gnt/sel return 0 in IDLE.
//  - Latency: req pulse cycle t -> pend t+1 -> go cycle t+2 (when idle). Back-to-back grants
//    separated by one IDLE cycle (RELEASE, IDLE, ISSUE).
//  - sel/gnt stable from ISSUE through RELEASE; busy=1 in ISSUE/WAIT/RELEASE.
//  - req arriving while busy only pends; never preempts.
//  - Reset mid-transaction: all outputs to reset values next edge; engine abort is engine's job.
// CONFIGURATION
//  RTC_ARB_TIMEOUT_EN defined: WAIT counter counts from 0; at TIMEOUT_CYCLES without
//    eng_done -> RELEASE with ack pulse, timeout_err set (sticky until reset), pend bit cleared.
//  Undefined: no counter, WAIT holds until eng_done forever, timeout_err tied 0.
// TESTING
//  - Reset released cycle 0 -> go=1, sel=1, gnt=5'b00001 at cycle 2; eng_done at 12 -> ack[0] at 13.
//  - req=5'b10110 one pulse while idle -> serves sel 3, then 4, then 2 in that order, 3 acks.
//  - REFRESH_CYCLES=100, no req -> go with sel=2 once per 100 cycles, 10 in 1000 cycles.
//  - req[1] pulsed during its own RELEASE -> second wr-time grant follows after one IDLE cycle.
//  - Macro on, TIMEOUT_CYCLES=16, no eng_done -> ack pulse, timeout_err=1 after 16 WAIT cycles;
//    macro off -> busy stays 1 for 1000 cycles, timeout_err=0.
//  - reset asserted during WAIT -> go/gnt/busy/sel=0 next cycle, init re-served after release.

Source files
------------

// File: rtl/rtc_bus_arbiter_if.sv
// Request/grant bundle between the RTC requesters and the shared transaction engine.
interface rtc_bus_arbiter_if;
  logic [4:0] req;
  logic       eng_done;
  logic       go;
  logic [2:0] sel;
  logic [4:0] gnt;
  logic [4:0] ack;
  logic       busy;
  logic       timeout_err;

  modport master (
    output req, eng_done,
    input  go, sel, gnt, ack, busy, timeout_err
  );

  modport slave (
    input  req, eng_done,
    output go, sel, gnt, ack, busy, timeout_err
  );
endinterface

// File: rtl/rtc_bus_arbiter.sv
// Fixed-priority arbiter for the shared RTC engine; req->go in 2 cycles, later requests only pend.
// Optional WAIT watchdog enabled by RTC_ARB_TIMEOUT_EN.
module rtc_bus_arbiter #(
  parameter int unsigned REFRESH_CYCLES = 12500000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic            clock,
  input  logic            reset,
  rtc_bus_arbiter_if.slave bus
);
  localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

  if (REFRESH_CYCLES < 4) begin : g_bad_refresh
    $error("REFRESH_CYCLES must be at least 4");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

  state_t        state, state_nx;
  logic [4:0]    pend, gnt_q, win_gnt, clr;
  logic [2:0]    sel_q, win_sel;
  logic [RW-1:0] ref_cnt;
  logic          ref_wrap, timeout_hit, to_err;
  logic          go, busy;

  // Refresh timer runs regardless of arbiter activity.
  assign ref_wrap = (ref_cnt == REF_LAST);

  always_ff @(posedge clock) begin
    if (reset)         ref_cnt <= '0;
    else if (ref_wrap) ref_cnt <= '0;
    else               ref_cnt <= ref_cnt + 1'b1;
  end

  // New requests beat the RELEASE clear so a re-request is never lost.
  assign clr = (state == RELEASE) ? gnt_q : 5'b00000;

  always_ff @(posedge clock) begin
    if (reset) pend <= 5'b00001;
    else       pend <= (pend & ~clr) | bus.req | {ref_wrap, 4'b0000};
  end

  always_comb begin
    win_gnt = 5'b00000;
    win_sel = 3'd0;
    if (pend[0])      begin win_gnt = 5'b00001; win_sel = 3'd1; end
    else if (pend[1]) begin win_gnt = 5'b00010; win_sel = 3'd3; end
    else if (pend[2]) begin win_gnt = 5'b00100; win_sel = 3'd4; end
    else if (pend[3]) begin win_gnt = 5'b01000; win_sel = 3'd5; end
    else if (pend[4]) begin win_gnt = 5'b10000; win_sel = 3'd2; end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    go       = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE:    if (|pend) state_nx = ISSUE;
      ISSUE:   begin go = 1'b1; busy = 1'b1; state_nx = WAIT; end
      WAIT:    begin busy = 1'b1; if (bus.eng_done || timeout_hit) state_nx = RELEASE; end
      RELEASE: begin busy = 1'b1; state_nx = IDLE; end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gnt_q <= 5'b00000;
      sel_q <= 3'd0;
    end else if (state == IDLE && |pend) begin
      gnt_q <= win_gnt;
      sel_q <= win_sel;
    end else if (state == RELEASE) begin
      gnt_q <= 5'b00000;
      sel_q <= 3'd0;
    end
  end

`ifdef RTC_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wait_cnt;

  // Abort on the last allowed WAIT cycle unless the engine finishes in that same cycle.
  assign timeout_hit = (state == WAIT) && !bus.eng_done && (wait_cnt == TO_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
      to_err   <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      if (timeout_hit) to_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign to_err      = 1'b0;
`endif

  assign bus.go          = go;
  assign bus.busy        = busy;
  assign bus.sel         = sel_q;
  assign bus.gnt         = gnt_q;
  assign bus.ack         = (state == RELEASE) ? gnt_q : 5'b00000;
  assign bus.timeout_err = to_err;
endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter: expected grants are queued when requests are driven and
// popped when the arbiter issues go.
module tb_rtc_bus_arbiter;
  logic clock = 1'b0;
  logic reset;

  rtc_bus_arbiter_if bus ();

  rtc_bus_arbiter #(
    .REFRESH_CYCLES(100),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] sel;
    logic [4:0] gnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [2:0] s, input logic [4:0] g);
    exp_t e;
    e.sel = s;
    e.gnt = g;
    exp_q.push_back(e);
  endtask

  // Leaves the bench in the first cycle after reset, with reset already dropped.
  task automatic do_reset();
    reset        = 1'b1;
    bus.req      = 5'b00000;
    bus.eng_done = 1'b0;
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
    push(3'd1, 5'b00001);
  endtask

  task automatic expect_go(input string tag, output bit ok, output exp_t e);
    ok = 1'b0;
    e  = '0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (bus.go === 1'b1) ok = 1'b1;
      else step();
    end
    chk({tag, "_go_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      chk({tag, "_queue"}, 32'(exp_q.size()), 32'(exp_q.size() == 0 ? 1 : exp_q.size()));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({tag, "_sel"}, 32'(bus.sel), 32'(e.sel));
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'(e.gnt));
      end
    end
  endtask

  task automatic serve(input string tag, input int wait_cycles, input bit early_done,
                       input logic [4:0] mid_req, input logic [4:0] rel_req);
    exp_t e;
    bit   ok;
    expect_go(tag, ok, e);
    if (!ok) return;
    chk({tag, "_busy_issue"}, 32'(bus.busy), 32'd1);
    if (early_done) bus.eng_done = 1'b1;
    step();
    bus.eng_done = 1'b0;
    chk({tag, "_go_pulse"}, 32'(bus.go), 32'd0);
    chk({tag, "_ack_wait"}, 32'(bus.ack), 32'd0);
    chk({tag, "_gnt_hold"}, 32'(bus.gnt), 32'(e.gnt));
    bus.req = mid_req;
    step();
    bus.req = 5'b00000;
    repeat (wait_cycles) step();
    chk({tag, "_gnt_wait"}, 32'(bus.gnt), 32'(e.gnt));
    bus.eng_done = 1'b1;
    step();
    bus.eng_done = 1'b0;
    chk({tag, "_ack"}, 32'(bus.ack), 32'(e.gnt));
    chk({tag, "_sel_rel"}, 32'(bus.sel), 32'(e.sel));
    chk({tag, "_busy_rel"}, 32'(bus.busy), 32'd1);
    bus.req = rel_req;
    step();
    bus.req = 5'b00000;
    chk({tag, "_ack_clr"}, 32'(bus.ack), 32'd0);
    chk({tag, "_idle"}, {26'd0, bus.busy, bus.gnt}, 32'd0);
    chk({tag, "_sel_idle"}, 32'(bus.sel), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bit   ok;
    int   n;
    bit   held;

    // Reset values and init auto-request timing.
    do_reset();
    chk("rst_go", 32'(bus.go), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_terr", 32'(bus.timeout_err), 32'd0);
    step();
    chk("init_go_c2", 32'(bus.go), 32'd1);
    expect_go("init", ok, e);
    repeat (10) step();
    chk("init_busy_c12", 32'(bus.busy), 32'd1);
    chk("init_ack_c12", 32'(bus.ack), 32'd0);
    bus.eng_done = 1'b1;
    step();
    bus.eng_done = 1'b0;
    chk("init_ack_c13", 32'(bus.ack), 32'd1);
    step();
    chk("init_busy_c14", 32'(bus.busy), 32'd0);

    // Multi-request priority order, early done ignored, no preemption.
    do_reset();
    serve("init2", 2, 1'b0, 5'b00000, 5'b00000);
    bus.req = 5'b10110;
    push(3'd3, 5'b00010);
    push(3'd4, 5'b00100);
    push(3'd2, 5'b10000);
    step();
    bus.req = 5'b00000;
    chk("lat_t1_go", 32'(bus.go), 32'd0);
    step();
    chk("lat_t2_go", 32'(bus.go), 32'd1);
    serve("wrtime", 1, 1'b1, 5'b00000, 5'b00000);
    serve("wrdate", 3, 1'b0, 5'b00000, 5'b00000);
    serve("readall", 0, 1'b0, 5'b00000, 5'b00000);
    bus.req = 5'b01000;
    push(3'd5, 5'b01000);
    step();
    bus.req = 5'b00000;
    push(3'd1, 5'b00001);
    serve("chrono", 2, 1'b0, 5'b00001, 5'b00000);
    serve("init_late", 1, 1'b0, 5'b00000, 5'b00000);

    // Re-request during RELEASE survives the clear; repeat pulses merge.
    do_reset();
    serve("init3", 1, 1'b0, 5'b00000, 5'b00000);
    bus.req = 5'b00010;
    step();
    bus.req = 5'b00010;
    step();
    bus.req = 5'b00000;
    push(3'd3, 5'b00010);
    push(3'd3, 5'b00010);
    serve("wt1", 1, 1'b0, 5'b00000, 5'b00010);
    chk("wt_idle_gap", 32'(bus.go), 32'd0);
    step();
    chk("wt_reissue", 32'(bus.go), 32'd1);
    serve("wt2", 1, 1'b0, 5'b00000, 5'b00000);
    step();
    step();
    chk("wt_no_extra", {30'd0, bus.busy, bus.go}, 32'd0);

    // Reset during WAIT.
    do_reset();
    expect_go("rst_a", ok, e);
    step();
    step();
    reset = 1'b1;
    step();
    chk("midrst_out", {20'd0, bus.go, bus.busy, bus.gnt, bus.sel, bus.ack[0]}, 32'd0);
    chk("midrst_ack", 32'(bus.ack), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    push(3'd1, 5'b00001);
    step();
    serve("rst_init", 1, 1'b0, 5'b00000, 5'b00000);

    // Periodic refresh with an auto-responding engine.
    do_reset();
    begin
      int dly;
      int n_ref;
      int last;
      int period;
      int first_sel;
      dly = 0; n_ref = 0; last = -1; period = 0; first_sel = -1;
      for (int c = 1; c <= 1100; c++) begin
        bus.eng_done = 1'b0;
        if (dly > 0) begin
          dly--;
          if (dly == 0) bus.eng_done = 1'b1;
        end
        if (bus.go === 1'b1) begin
          dly = 3;
          if (first_sel < 0) first_sel = int'(bus.sel);
          if (bus.sel === 3'd2) begin
            if (c >= 50 && c < 1050) n_ref++;
            if (last >= 0) period = c - last;
            last = c;
          end
        end
        step();
      end
      bus.eng_done = 1'b0;
      chk("ref_first_init", 32'(first_sel), 32'd1);
      chk("ref_count", 32'(n_ref), 32'd10);
      chk("ref_period", 32'(period), 32'd100);
    end

    // Engine never answers.
    do_reset();
    expect_go("to", ok, e);
    step();
`ifdef RTC_ARB_TIMEOUT_EN
    n = 0;
    while (bus.ack === 5'b00000 && n < 100) begin
      n++;
      step();
    end
    chk("to_wait_cycles", 32'(n), 32'd16);
    chk("to_ack", 32'(bus.ack), 32'd1);
    chk("to_err_set", 32'(bus.timeout_err), 32'd1);
    step();
    chk("to_err_sticky", 32'(bus.timeout_err), 32'd1);
    chk("to_idle", 32'(bus.busy), 32'd0);
    do_reset();
    chk("to_err_reset", 32'(bus.timeout_err), 32'd0);
`else
    held = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (bus.busy !== 1'b1 || bus.ack !== 5'b00000 || bus.timeout_err !== 1'b0) held = 1'b0;
      step();
    end
    chk("hold_busy_1000", 32'(held), 32'd1);
    chk("hold_terr", 32'(bus.timeout_err), 32'd0);
    bus.eng_done = 1'b1;
    step();
    bus.eng_done = 1'b0;
    chk("hold_ack", 32'(bus.ack), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
